// File: rtl/uaz_data_bus_responder.sv
// Data-side bus responder for the MicroUAZ core: data RAM plus a small I/O page
// (GPIO out, synchronised GPIO in, prescaled 8-bit timer with a sticky overflow).
module uaz_data_bus_responder #(
  parameter int         RAM_DEPTH = 240,
  parameter int         PRESCALE  = 4,
  parameter logic [7:0] IO_BASE   = 8'hF0
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [7:0] i_Address,
  input  logic [7:0] i_DataOut,
  input  logic       i_ReadWrite,
  output logic [7:0] o_DataIn,
  input  logic [7:0] i_Gpio,
  output logic [7:0] o_Gpio,
  output logic       o_TimerIrq
);

  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [8:0]    RAM_END  = 9'(RAM_DEPTH);

  logic [7:0]    ram [RAM_DEPTH];
  logic [7:0]    dout_reg;
  logic [7:0]    gpio_out_reg;
  logic [7:0]    sync1_reg;
  logic [7:0]    sync2_reg;
  logic [7:0]    timer_reg;
  logic [PW-1:0] pre_reg;
  logic          en_reg;
  logic          ovf_reg;

  logic          is_ram;
  logic          is_io;
  logic [7:0]    io_off;
  logic [AW-1:0] ram_idx;
  logic          wr_gpio;
  logic          wr_timer;
  logic          wr_ctrl;
  logic          wr_status;
  logic          tick;
  logic          clr;
  logic          ovf_set;
  logic [7:0]    rd_data;

  assign is_ram    = ({1'b0, i_Address} < RAM_END);
  assign is_io     = (i_Address >= IO_BASE);
  assign io_off    = i_Address - IO_BASE;
  assign ram_idx   = i_Address[AW-1:0];

  assign wr_gpio   = i_ReadWrite && is_io && (io_off == 8'd0);
  assign wr_timer  = i_ReadWrite && is_io && (io_off == 8'd2);
  assign wr_ctrl   = i_ReadWrite && is_io && (io_off == 8'd3);
  assign wr_status = i_ReadWrite && is_io && (io_off == 8'd4);

  assign tick      = en_reg && (pre_reg == PRE_LAST);
  assign clr       = wr_ctrl && i_DataOut[1];
  // A load or clear on the wrap edge discards the increment, so it cannot overflow.
  assign ovf_set   = tick && (timer_reg == 8'hFF) && !clr && !wr_timer;

  always_comb begin
    rd_data = 8'h00;
    if (is_ram) begin
      rd_data = ram[ram_idx];
    end else if (is_io) begin
      case (io_off)
        8'd0:    rd_data = gpio_out_reg;
        8'd1:    rd_data = sync2_reg;
        8'd2:    rd_data = timer_reg;
        8'd3:    rd_data = {7'd0, en_reg};
        8'd4:    rd_data = {7'd0, ovf_reg};
        default: rd_data = 8'h00;
      endcase
    end
  end

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge i_Clk) begin
    if (i_ReadWrite && is_ram) begin
      ram[ram_idx] <= i_DataOut;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      dout_reg     <= 8'h00;
      gpio_out_reg <= 8'h00;
      sync1_reg    <= 8'h00;
      sync2_reg    <= 8'h00;
      timer_reg    <= 8'h00;
      pre_reg      <= '0;
      en_reg       <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      sync1_reg <= i_Gpio;
      sync2_reg <= sync1_reg;

      if (!i_ReadWrite) begin
        dout_reg <= rd_data;
      end

      if (wr_gpio) begin
        gpio_out_reg <= i_DataOut;
      end

      if (wr_ctrl) begin
        en_reg <= i_DataOut[0];
      end

      if (clr) begin
        timer_reg <= 8'h00;
        pre_reg   <= '0;
      end else if (wr_timer) begin
        timer_reg <= i_DataOut;
        pre_reg   <= '0;
      end else if (en_reg) begin
        if (tick) begin
          pre_reg   <= '0;
          timer_reg <= timer_reg + 8'd1;
        end else begin
          pre_reg <= pre_reg + 1'b1;
        end
      end

      if (ovf_set) begin
        ovf_reg <= 1'b1;
      end else if (wr_status && i_DataOut[0]) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  assign o_DataIn   = dout_reg;
  assign o_Gpio     = gpio_out_reg;
  assign o_TimerIrq = ovf_reg;

endmodule

// File: tb/tb_uaz_data_bus_responder.sv
// Directed bench for uaz_data_bus_responder: a behavioural bus/timer model checked
// on every falling edge, plus hand-computed literal expectations.
module tb_uaz_data_bus_responder;

  localparam int         RAM_DEPTH = 240;
  localparam int         PRESCALE  = 4;
  localparam logic [7:0] IO_BASE   = 8'hF0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       rw = 1'b0;
  logic [7:0] gpio_in = 8'h00;
  logic [7:0] data_in;
  logic [7:0] gpio_out;
  logic       irq;

  int checks = 0;
  int failures = 0;

  uaz_data_bus_responder #(
    .RAM_DEPTH(RAM_DEPTH),
    .PRESCALE (PRESCALE),
    .IO_BASE  (IO_BASE)
  ) dut (
    .i_Clk      (clk),
    .i_Reset    (rst_n),
    .i_Address  (addr),
    .i_DataOut  (wdata),
    .i_ReadWrite(rw),
    .o_DataIn   (data_in),
    .i_Gpio     (gpio_in),
    .o_Gpio     (gpio_out),
    .o_TimerIrq (irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: memory map as plain arrays and integers.
  byte unsigned m_mem [256];
  bit           m_known [256];
  byte unsigned m_gpio_out = 0, m_s1 = 0, m_s2 = 0, m_timer = 0, m_dout = 0;
  int           m_pre = 0;
  bit           m_en = 0, m_ovf = 0, m_dout_known = 1;

  function automatic byte unsigned model_read(input int a, output bit known);
    known = 1;
    if (a < RAM_DEPTH) begin
      known = m_known[a];
      return m_mem[a];
    end
    if (a < int'(IO_BASE)) return 0;
    case (a - int'(IO_BASE))
      0: return m_gpio_out;
      1: return m_s2;
      2: return m_timer;
      3: return byte'(m_en);
      4: return byte'(m_ovf);
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_gpio_out = 0; m_s1 = 0; m_s2 = 0; m_timer = 0; m_dout = 0;
      m_pre = 0; m_en = 0; m_ovf = 0; m_dout_known = 1;
    end else begin
      int a, off;
      bit k, wrap, load, clear;
      byte unsigned rv;
      a = int'(addr);
      off = a - int'(IO_BASE);
      rv = model_read(a, k);
      wrap  = m_en && (m_pre == PRESCALE - 1);
      load  = rw && a >= int'(IO_BASE) && off == 2;
      clear = rw && a >= int'(IO_BASE) && off == 3 && wdata[1];
      if (!rw) begin
        m_dout = rv;
        m_dout_known = k;
      end
      if (clear) begin
        m_timer = 0; m_pre = 0;
      end else if (load) begin
        m_timer = wdata; m_pre = 0;
      end else if (m_en) begin
        if (wrap) begin
          m_pre = 0;
          if (m_timer == 255) m_ovf = 1;
          m_timer = byte'((int'(m_timer) + 1) % 256);
        end else begin
          m_pre = m_pre + 1;
        end
      end
      if (rw && a < RAM_DEPTH) begin
        m_mem[a] = wdata; m_known[a] = 1;
      end
      if (rw && a >= int'(IO_BASE)) begin
        if (off == 0) m_gpio_out = wdata;
        if (off == 3) m_en = wdata[0];
        if (off == 4 && wdata[0] && !(wrap && m_timer == 0 && !load && !clear)) m_ovf = 0;
      end
      m_s2 = m_s1;
      m_s1 = gpio_in;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h required=%02h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_gpio", gpio_out, m_gpio_out);
      check("model_irq", {7'd0, irq}, {7'd0, m_ovf});
      if (m_dout_known) check("model_dout", data_in, m_dout);
    end
  end

  task automatic cyc(input logic [7:0] a, input logic [7:0] d, input logic w);
    addr = a; wdata = d; rw = w;
    @(negedge clk);
    $display("txn %s addr=%02h wdata=%02h dout=%02h gpio=%02h irq=%0b",
             w ? "WR" : "RD", a, d, data_in, gpio_out, irq);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("reset_dout", data_in, 8'h00);
    check("reset_gpio", gpio_out, 8'h00);
    check("reset_irq", {7'd0, irq}, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < RAM_DEPTH; i++) begin
      addr = 8'(i); wdata = 8'h00; rw = 1'b1;
      @(negedge clk);
    end

    cyc(8'h07, 8'h83, 1'b1);
    cyc(8'h07, 8'h00, 1'b0);
    check("ram_rd_07", data_in, 8'h83);
    cyc(8'h06, 8'h00, 1'b0);
    check("ram_rd_06", data_in, 8'h00);
    cyc(8'hEF, 8'h5A, 1'b1);
    check("write_holds_dout", data_in, 8'h00);
    cyc(8'hEF, 8'h00, 1'b0);
    check("ram_rd_last", data_in, 8'h5A);

    cyc(8'hF0, 8'h55, 1'b1);
    cyc(8'hF0, 8'h00, 1'b0);
    check("gpio_out_pin", gpio_out, 8'h55);
    check("gpio_out_rd", data_in, 8'h55);
    cyc(8'hF8, 8'hAA, 1'b1);
    cyc(8'hF8, 8'h00, 1'b0);
    check("unmapped_f8", data_in, 8'h00);
    cyc(8'hF1, 8'hFF, 1'b1);
    cyc(8'hF5, 8'h00, 1'b0);
    check("unmapped_f5", data_in, 8'h00);

    cyc(8'hF1, 8'h00, 1'b0);
    cyc(8'hF1, 8'h00, 1'b0);
    check("gpio_in_base", data_in, 8'h00);
    gpio_in = 8'h3C;
    cyc(8'hF1, 8'h00, 1'b0);
    cyc(8'hF1, 8'h00, 1'b0);
    check("gpio_in_edge2", data_in, 8'h00);
    cyc(8'hF1, 8'h00, 1'b0);
    check("gpio_in_edge3", data_in, 8'h3C);

    cyc(8'hF2, 8'hFE, 1'b1);
    cyc(8'hF3, 8'h01, 1'b1);
    for (int i = 0; i < 5; i++) cyc(8'hF2, 8'h00, 1'b0);
    check("timer_ff", data_in, 8'hFF);
    check("irq_before_wrap", {7'd0, irq}, 8'h00);
    for (int i = 0; i < 4; i++) cyc(8'hF2, 8'h00, 1'b0);
    check("timer_wrap", data_in, 8'h00);
    check("irq_set", {7'd0, irq}, 8'h01);
    for (int i = 0; i < 6; i++) cyc(8'hF4, 8'h00, 1'b0);
    check("irq_sticky", {7'd0, irq}, 8'h01);
    check("status_rd", data_in, 8'h01);
    cyc(8'hF4, 8'h01, 1'b1);
    check("irq_cleared", {7'd0, irq}, 8'h00);

    cyc(8'hF2, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) cyc(8'hF2, 8'h00, 1'b0);
    check("timer_pre_wrap", data_in, 8'hFF);
    cyc(8'hF4, 8'h01, 1'b1);
    check("ovf_beats_clear", {7'd0, irq}, 8'h01);

    cyc(8'hF3, 8'h03, 1'b1);
    cyc(8'hF2, 8'h00, 1'b0);
    check("ctrl_clear_timer", data_in, 8'h00);
    cyc(8'hF3, 8'h00, 1'b0);
    check("ctrl_rd", data_in, 8'h01);
    for (int i = 0; i < 6; i++) cyc(8'hF2, 8'h00, 1'b0);
    check("timer_running", data_in, 8'h01);

    #2 rst_n = 1'b0;
    #1;
    check("midrst_dout", data_in, 8'h00);
    check("midrst_gpio", gpio_out, 8'h00);
    check("midrst_irq", {7'd0, irq}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc(8'hF2, 8'h00, 1'b0);
    check("post_rst_timer", data_in, 8'h00);
    cyc(8'hF3, 8'h00, 1'b0);
    check("post_rst_ctrl", data_in, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
